midi_tx: RTL and testbench

Serial MIDI transmitter sitting directly downstream of the wb_midi peripheral. It takes the parallel status/data1/data2 message and a one-cycle send strobe, then emits the bytes on a 31250-baud 8N1 MIDI OUT line. It derives message length from the status byte and optionally applies running status. Hook-up in the top level: send comes from a wb_midi write strobe; midi_txd drives the MIDI OUT pin.

---
 rtl/midi_tx.sv | 205 ++++++++++++++++++++
 tb/tb_midi_tx.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_tx.sv
// midi_tx: serial MIDI OUT transmitter (31250 baud, 8N1).
// Takes a status/data1/data2 message on a one-cycle send strobe. The number of
// bytes is decoded from the status byte. A repeated channel status byte can be
// omitted (running status).
module midi_tx #(
   parameter int clk_freq       = 100000000,
   parameter int baud           = 31250,
   parameter int running_status = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] status,
   input  logic [7:0] data1,
   input  logic [7:0] data2,
   input  logic       send,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       midi_txd
);

   localparam int DIV = clk_freq / baud;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] baud_cnt_reg, baud_cnt_next;
   logic [2:0]    bit_cnt_reg, bit_cnt_next;
   logic [7:0]    shift_reg, shift_next;
   logic [7:0]    byte1_reg, byte1_next;   // next byte to send after the current one
   logic [7:0]    byte2_reg, byte2_next;   // byte after that
   logic [1:0]    remain_reg, remain_next; // bytes still queued behind shift_reg
   logic [7:0]    rs_reg, rs_next;         // stored running status
   logic          rs_valid_reg, rs_valid_next;
   logic          txd_reg, txd_next;
   logic          busy_reg, busy_next;
   logic          done_reg, done_next;
   logic          err_reg, err_next;

   logic [1:0]    msg_bytes;
   logic          is_channel;
   logic          skip_status;
   logic          baud_end;

   // Total message length in bytes, status byte included.
   function automatic logic [1:0] msg_len(input logic [7:0] s);
      logic [1:0] n;
      case (s[7:4])
         4'h8, 4'h9, 4'hA, 4'hB, 4'hE: n = 2'd3;
         4'hC, 4'hD:                   n = 2'd2;
         4'hF: begin
            case (s[3:0])
               4'h1, 4'h3: n = 2'd2;
               4'h2:       n = 2'd3;
               default:    n = 2'd1;
            endcase
         end
         default: n = 2'd1;
      endcase
      return n;
   endfunction

   assign msg_bytes   = msg_len(status);
   assign is_channel  = status[7] && (status[7:4] != 4'hF);
   assign skip_status = (running_status != 0) && is_channel && rs_valid_reg && (rs_reg == status);
   assign baud_end    = (baud_cnt_reg == BAUD_LAST);

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         baud_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         shift_reg    <= '0;
         byte1_reg    <= '0;
         byte2_reg    <= '0;
         remain_reg   <= '0;
         rs_reg       <= '0;
         rs_valid_reg <= 1'b0;
         txd_reg      <= 1'b1;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         baud_cnt_reg <= baud_cnt_next;
         bit_cnt_reg  <= bit_cnt_next;
         shift_reg    <= shift_next;
         byte1_reg    <= byte1_next;
         byte2_reg    <= byte2_next;
         remain_reg   <= remain_next;
         rs_reg       <= rs_next;
         rs_valid_reg <= rs_valid_next;
         txd_reg      <= txd_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
         err_reg      <= err_next;
      end
   end

   // Next-state logic: message acceptance, bit timing and byte sequencing.
   always_comb begin
      state_next    = state_reg;
      baud_cnt_next = baud_cnt_reg;
      bit_cnt_next  = bit_cnt_reg;
      shift_next    = shift_reg;
      byte1_next    = byte1_reg;
      byte2_next    = byte2_reg;
      remain_next   = remain_reg;
      rs_next       = rs_reg;
      rs_valid_next = rs_valid_reg;
      txd_next      = txd_reg;
      busy_next     = busy_reg;
      done_next     = 1'b0;
      err_next      = 1'b0;

      case (state_reg)
         IDLE: begin
            txd_next  = 1'b1;
            busy_next = 1'b0;
            if (send) begin
               if (!status[7]) begin
                  err_next = 1'b1;
               end else begin
                  if (skip_status) begin
                     shift_next  = data1;
                     byte1_next  = data2;
                     remain_next = msg_bytes - 2'd2;
                  end else begin
                     shift_next  = status;
                     byte1_next  = data1;
                     byte2_next  = data2;
                     remain_next = msg_bytes - 2'd1;
                  end
                  // Channel messages set the running status, system common
                  // messages clear it, real-time messages leave it alone.
                  if (is_channel) begin
                     rs_next       = status;
                     rs_valid_next = 1'b1;
                  end else if (status[7:3] == 5'b11110) begin
                     rs_valid_next = 1'b0;
                  end
                  baud_cnt_next = '0;
                  txd_next      = 1'b0;
                  busy_next     = 1'b1;
                  state_next    = START;
               end
            end
         end
         START: begin
            if (baud_end) begin
               baud_cnt_next = '0;
               bit_cnt_next  = '0;
               txd_next      = shift_reg[0];
               state_next    = DATA;
            end else begin
               baud_cnt_next = baud_cnt_reg + 1'b1;
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_cnt_next = '0;
               if (bit_cnt_reg == 3'd7) begin
                  txd_next   = 1'b1;
                  state_next = STOP;
               end else begin
                  bit_cnt_next = bit_cnt_reg + 1'b1;
                  shift_next   = {1'b0, shift_reg[7:1]};
                  txd_next     = shift_reg[1];
               end
            end else begin
               baud_cnt_next = baud_cnt_reg + 1'b1;
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_cnt_next = '0;
               if (remain_reg != 2'd0) begin
                  shift_next  = byte1_reg;
                  byte1_next  = byte2_reg;
                  remain_next = remain_reg - 2'd1;
                  txd_next    = 1'b0;
                  state_next  = START;
               end else begin
                  txd_next   = 1'b1;
                  busy_next  = 1'b0;
                  done_next  = 1'b1;
                  state_next = IDLE;
               end
            end else begin
               baud_cnt_next = baud_cnt_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign midi_txd = txd_reg;
   assign busy     = busy_reg;
   assign done     = done_reg;
   assign err      = err_reg;

endmodule

// File: tb/tb_midi_tx.sv
// tb_midi_tx: scoreboard bench for midi_tx. Two instances (running status on
// and off) are exercised one at a time. Stimulus pushes expected bytes and
// busy durations; monitors decode the serial line and busy/done and compare.
module tb_midi_tx;

   localparam int CLK_F    = 500000;
   localparam int BAUD     = 31250;
   localparam int DIV      = CLK_F / BAUD;
   localparam int BYTE_CYC = 10 * DIV;
   localparam int MAXW     = 3 * BYTE_CYC + 20;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] status, data1, data2;
   logic       send [2];
   logic       busy [2];
   logic       done [2];
   logic       err  [2];
   logic       txd  [2];

   int checks = 0;
   int fails  = 0;
   int exp_q[$];   // expected serial bytes, in order
   int dur_q[$];   // expected busy length in cycles, per message
   logic [7:0] rs_m  [2];
   bit         rsv_m [2];

   always #5 clk = ~clk;

   midi_tx #(.clk_freq(CLK_F), .baud(BAUD), .running_status(1)) dut_rs (
      .clk(clk), .rst(rst), .status(status), .data1(data1), .data2(data2),
      .send(send[0]), .busy(busy[0]), .done(done[0]), .err(err[0]), .midi_txd(txd[0]));

   midi_tx #(.clk_freq(CLK_F), .baud(BAUD), .running_status(0)) dut_nors (
      .clk(clk), .rst(rst), .status(status), .data1(data1), .data2(data2),
      .send(send[1]), .busy(busy[1]), .done(done[1]), .err(err[1]), .midi_txd(txd[1]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      fails++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Reference model: message length from the MIDI status classes.
   function automatic int msg_len(input logic [7:0] s);
      if (s >= 8'hF8) return 1;
      if (s == 8'hF1 || s == 8'hF3) return 2;
      if (s == 8'hF2) return 3;
      if (s >= 8'hF0) return 1;
      if (s >= 8'hC0 && s < 8'hE0) return 2;
      return 3;
   endfunction

   task automatic model_push(input int k, input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2);
      int  n;
      int  sent;
      bit  skip;
      n    = msg_len(s);
      skip = (k == 0) && (s >= 8'h80) && (s < 8'hF0) && rsv_m[k] && (rs_m[k] == s);
      sent = 0;
      if (!skip) begin exp_q.push_back(int'(s)); sent++; end
      if (n >= 2) begin exp_q.push_back(int'(d1)); sent++; end
      if (n == 3) begin exp_q.push_back(int'(d2)); sent++; end
      dur_q.push_back(sent * BYTE_CYC);
      if (s < 8'hF0) begin
         rs_m[k]  = s;
         rsv_m[k] = 1'b1;
      end else if (s < 8'hF8) begin
         rsv_m[k] = 1'b0;
      end
   endtask

   task automatic skip_cycles(input int n, output bit aborted);
      aborted = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (rst) begin
            aborted = 1'b1;
            break;
         end
      end
   endtask

   // Serial decoder: samples each bit in its middle and scores the byte.
   task automatic mon_bytes(input int k);
      logic [7:0] b;
      bit         ab;
      int         e;
      forever begin
         @(negedge clk);
         if (!rst && txd[k] == 1'b0) begin
            b = '0;
            skip_cycles(DIV / 2, ab);
            if (!ab) check("start_bit", txd[k], 1'b0);
            for (int i = 0; i < 8; i++) begin
               if (!ab) begin
                  skip_cycles(DIV, ab);
                  b[i] = txd[k];
               end
            end
            if (!ab) skip_cycles(DIV, ab);
            if (!ab) begin
               check("stop_bit", txd[k], 1'b1);
               if (exp_q.size() == 0) begin
                  flag($sformatf("unexpected_byte inst%0d got %02h, none expected", k, b));
               end else begin
                  e = exp_q.pop_front();
                  check($sformatf("byte inst%0d", k), b, e);
                  $display("inst%0d byte %02h (expected %02h)", k, b, e);
               end
            end
         end
      end
   endtask

   // Busy/done monitor: measures each busy run and checks done ends it.
   task automatic mon_busy(input int k);
      int cnt = 0;
      int e;
      forever begin
         @(negedge clk);
         if (rst) begin
            cnt = 0;
         end else if (busy[k]) begin
            cnt++;
         end else if (cnt > 0) begin
            check($sformatf("done_at_busy_end inst%0d", k), done[k], 1'b1);
            if (dur_q.size() == 0) begin
               flag($sformatf("unexpected_message inst%0d busy %0d cycles", k, cnt));
            end else begin
               e = dur_q.pop_front();
               check($sformatf("busy_cycles inst%0d", k), cnt, e);
               $display("inst%0d message done after %0d cycles (expected %0d)", k, cnt, e);
            end
            cnt = 0;
         end else if (done[k]) begin
            check($sformatf("spurious_done inst%0d", k), done[k], 1'b0);
         end
      end
   endtask

   // Issue a send at the current negedge; returns at the following negedge.
   task automatic do_send(input int k, input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2);
      status  = s;
      data1   = d1;
      data2   = d2;
      if (s[7]) model_push(k, s, d1, d2);
      send[k] = 1'b1;
      @(negedge clk);
      send[k] = 1'b0;
      if (!s[7]) begin
         check("err_pulse", err[k], 1'b1);
         check("err_busy", busy[k], 1'b0);
         check("err_txd", txd[k], 1'b1);
         @(negedge clk);
         check("err_one_cycle", err[k], 1'b0);
         check("err_txd_after", txd[k], 1'b1);
         $display("inst%0d status %02h rejected", k, s);
      end else begin
         check("busy_after_send", busy[k], 1'b1);
         check("start_after_send", txd[k], 1'b0);
         check("no_err_valid", err[k], 1'b0);
      end
   endtask

   task automatic send_ignored(input int k, input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2);
      check("busy_before_ignored", busy[k], 1'b1);
      status  = s;
      data1   = d1;
      data2   = d2;
      send[k] = 1'b1;
      @(negedge clk);
      send[k] = 1'b0;
      check("no_err_ignored", err[k], 1'b0);
   endtask

   task automatic wait_done(input int k);
      bit got = 1'b0;
      for (int i = 0; i < MAXW; i++) begin
         @(negedge clk);
         if (done[k]) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) flag($sformatf("done_timeout inst%0d", k));
   endtask

   initial begin
      fork
         mon_bytes(0);
         mon_bytes(1);
         mon_busy(0);
         mon_busy(1);
      join_none
   end

   initial begin
      repeat (200000) @(posedge clk);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] s;
      int         r;
      rst     = 1'b1;
      send[0] = 1'b0;
      send[1] = 1'b0;
      status  = '0;
      data1   = '0;
      data2   = '0;
      rsv_m[0] = 1'b0;
      rsv_m[1] = 1'b0;
      rs_m[0]  = '0;
      rs_m[1]  = '0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check("reset_txd", txd[k], 1'b1);
         check("reset_busy", busy[k], 1'b0);
         check("reset_done", done[k], 1'b0);
         check("reset_err", err[k], 1'b0);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);

      // Note-on, then back-to-back running-status note-on.
      do_send(0, 8'h90, 8'h3C, 8'h64);
      wait_done(0);
      do_send(0, 8'h90, 8'h3C, 8'h00);
      wait_done(0);

      // Same pair without running status.
      @(negedge clk);
      do_send(1, 8'h90, 8'h3C, 8'h64);
      wait_done(1);
      do_send(1, 8'h90, 8'h3C, 8'h00);
      wait_done(1);

      // Length decode and running-status bookkeeping.
      @(negedge clk);
      do_send(0, 8'hC5, 8'h07, 8'h55);
      wait_done(0);
      do_send(0, 8'h90, 8'h40, 8'h41);
      wait_done(0);
      do_send(0, 8'hF8, 8'h11, 8'h22);
      wait_done(0);
      do_send(0, 8'h90, 8'h42, 8'h43);
      wait_done(0);
      do_send(0, 8'hF2, 8'h05, 8'h06);
      wait_done(0);
      do_send(0, 8'h90, 8'h44, 8'h45);
      wait_done(0);

      // Invalid status and a send while busy.
      @(negedge clk);
      do_send(0, 8'h3C, 8'h01, 8'h02);
      do_send(0, 8'hE3, 8'h11, 8'h22);
      repeat (50) @(negedge clk);
      send_ignored(0, 8'h80, 8'h01, 8'h02);
      wait_done(0);

      // Reset during data bit 4 of the second byte.
      do_send(0, 8'hF2, 8'h0A, 8'h0B);
      wait_done(0);
      do_send(0, 8'h90, 8'h12, 8'h34);
      repeat (BYTE_CYC + 5 * DIV + DIV / 2 - 1) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_txd", txd[0], 1'b1);
      check("abort_busy", busy[0], 1'b0);
      check("abort_done", done[0], 1'b0);
      exp_q.delete();
      dur_q.delete();
      rsv_m[0] = 1'b0;
      rsv_m[1] = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2 * DIV) @(negedge clk);
      check("post_reset_idle_txd", txd[0], 1'b1);
      do_send(0, 8'h90, 8'h12, 8'h34);
      wait_done(0);

      // Randomized messages, some back-to-back, some with ignored sends.
      for (int it = 0; it < 14; it++) begin
         r = int'($urandom_range(0, 4));
         case (r)
            0, 1:    s = 8'h90;
            2:       s = 8'($urandom_range(0, 255));
            3:       s = 8'($urandom_range(8'h80, 8'hEF));
            default: s = 8'($urandom_range(8'hF0, 8'hFF));
         endcase
         do_send(0, s, 8'($urandom_range(0, 127)), 8'($urandom_range(0, 127)));
         if (s[7]) begin
            if ($urandom_range(0, 1) == 1) begin
               repeat ($urandom_range(1, 100)) @(negedge clk);
               send_ignored(0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            end
            wait_done(0);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (2 * DIV) @(negedge clk);
      check("bytes_left_in_scoreboard", exp_q.size(), 0);
      check("messages_left_in_scoreboard", dur_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
